// File: rtl/m_ext_unit.sv
// Iterative RISC-V M-extension unit: shift-add multiply and restoring divide
// on operand magnitudes, one bit per cycle. Divide special cases finish in one cycle.
module m_ext_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_r, next_s;
  logic [CW-1:0]     cnt_r;
  logic [XLEN-1:0]   hi_r, lo_r, opnd_r, result_r;
  logic [1:0]        op_r;
  logic              neg_q_r, neg_r_r, busy_r, done_r, busy_s, done_s;

  logic              sgn1_en_s, sgn2_en_s, s1_s, s2_s, div0_s, ovf_s, special_s, last_s;
  logic [XLEN-1:0]   mag1_s, mag2_s, special_val_s;
  logic [XLEN:0]     msum_s, drs_s, ddiff_s;
  logic [XLEN-1:0]   mhi_s, mlo_s, dhi_s, dlo_s, mres_s, dres_s, quo_s, rem_s;
  logic              dge_s;
  logic [2*XLEN-1:0] prod_s;

  // Operand decode at start: signedness, magnitudes and one-cycle divide cases
  always_comb begin
    sgn1_en_s = func3[2] ? ~func3[0] : (func3[1:0] != 2'b11);
    sgn2_en_s = func3[2] ? ~func3[0] : ~func3[1];
    s1_s      = sgn1_en_s & op1[XLEN-1];
    s2_s      = sgn2_en_s & op2[XLEN-1];
    mag1_s    = s1_s ? -op1 : op1;
    mag2_s    = s2_s ? -op2 : op2;
    div0_s    = (op2 == {XLEN{1'b0}});
    ovf_s     = ~func3[0] && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == {XLEN{1'b1}});
    special_s = func3[2] & (div0_s | ovf_s);
    if (div0_s) begin
      special_val_s = func3[1] ? op1 : {XLEN{1'b1}};
    end else begin
      special_val_s = func3[1] ? {XLEN{1'b0}} : op1;
    end
  end

  // One iteration step of each datapath plus final sign fix-up and result select
  always_comb begin
    last_s  = (cnt_r == CW'(XLEN-1));
    msum_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
    mhi_s   = msum_s[XLEN:1];
    mlo_s   = {msum_s[0], lo_r[XLEN-1:1]};
    drs_s   = {hi_r, lo_r[XLEN-1]};
    ddiff_s = drs_s - {1'b0, opnd_r};
    dge_s   = ~ddiff_s[XLEN];
    dhi_s   = dge_s ? ddiff_s[XLEN-1:0] : drs_s[XLEN-1:0];
    dlo_s   = {lo_r[XLEN-2:0], dge_s};
    prod_s  = neg_q_r ? -{mhi_s, mlo_s} : {mhi_s, mlo_s};
    mres_s  = (op_r == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    quo_s   = neg_q_r ? -dlo_s : dlo_s;
    rem_s   = neg_r_r ? -dhi_s : dhi_s;
    dres_s  = op_r[1] ? rem_s : quo_s;
  end

  // Next-state and output decode; flush wins over any start
  always_comb begin
    next_s = state_r;
    if (flush) begin
      next_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (!start) begin
            next_s = S_IDLE;
          end else if (special_s) begin
            next_s = S_DONE;
          end else if (func3[2]) begin
            next_s = S_DIV;
          end else begin
            next_s = S_MUL;
          end
        end
        S_MUL, S_DIV: begin
          if (last_s) begin
            next_s = S_DONE;
          end else begin
            next_s = state_r;
          end
        end
        default: next_s = S_IDLE;
      endcase
    end
    busy_s = (next_s == S_MUL) || (next_s == S_DIV);
    done_s = (next_s == S_DONE);
  end

  // State and status flag registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Datapath: operand capture, per-bit iteration and result capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r    <= {CW{1'b0}};
      hi_r     <= {XLEN{1'b0}};
      lo_r     <= {XLEN{1'b0}};
      opnd_r   <= {XLEN{1'b0}};
      op_r     <= 2'b00;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      result_r <= {XLEN{1'b0}};
    end else if (flush) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            cnt_r   <= {CW{1'b0}};
            op_r    <= func3[1:0];
            neg_q_r <= s1_s ^ s2_s;
            neg_r_r <= s1_s;
            hi_r    <= {XLEN{1'b0}};
            lo_r    <= func3[2] ? mag1_s : mag2_s;
            opnd_r  <= func3[2] ? mag2_s : mag1_s;
            if (special_s) begin
              result_r <= special_val_s;
            end
          end
        end
        S_MUL: begin
          cnt_r <= cnt_r + CW'(1);
          hi_r  <= mhi_s;
          lo_r  <= mlo_s;
          if (last_s) begin
            result_r <= mres_s;
          end
        end
        S_DIV: begin
          cnt_r <= cnt_r + CW'(1);
          hi_r  <= dhi_s;
          lo_r  <= dlo_s;
          if (last_s) begin
            result_r <= dres_s;
          end
        end
        default: cnt_r <= {CW{1'b0}};
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_m_ext_unit.sv
// Self-checking bench for m_ext_unit: cycle-count reference model compared every
// cycle, directed literal checks and a randomized stimulus phase.
module tb_m_ext_unit;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, start, flush, busy, done;
  logic [2:0]      func3;
  logic [XLEN-1:0] op1, op2, result;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  m_ext_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .func3(func3), .op1(op1), .op2(op2),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Reference arithmetic straight from the ISA definitions, using 64-bit integers
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = 64'd0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Timing model: m_left counts cycles until done (1 = done cycle, 0 = idle)
  int          m_left = 0;
  int          nl;
  logic [31:0] m_pend = 32'd0, m_res = 32'd0, pv;
  logic        m_busy = 1'b0, m_done = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m_left <= 0; m_res <= 32'd0; m_busy <= 1'b0; m_done <= 1'b0;
    end else if (flush) begin
      m_left <= 0; m_busy <= 1'b0; m_done <= 1'b0;
    end else begin
      nl = (m_left > 0) ? m_left - 1 : 0;
      pv = m_pend;
      if (start && m_left <= 1) begin
        nl = is_special(func3, op1, op2) ? 1 : XLEN + 1;
        pv = ref_op(func3, op1, op2);
      end
      m_pend <= pv;
      m_left <= nl;
      m_busy <= (nl > 1);
      m_done <= (nl == 1);
      if (nl == 1) m_res <= pv;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("result", result, m_res);
      chk("busy_and_done", {31'd0, busy & done}, 32'd0);
    end
  end

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge (cycle 0); returns at the negedge of the done cycle
  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    func3 = f; op1 = a; op2 = b; start = 1'b1;
    @(negedge clk);
    n = 1;
    start = 1'b0;
    func3 = 3'($urandom); op1 = $urandom; op2 = $urandom;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      start = (n == 5);
      if (n == 5) begin
        func3 = 3'($urandom); op1 = $urandom; op2 = $urandom;
      end
    end
    start = 1'b0;
    chk({nm, "_latency"}, 32'(n), 32'(lat));
    chk({nm, "_result"}, result, exp);
  endtask

  bit seen;

  initial begin
    rst = 1'b0; start = 1'b0; flush = 1'b0; func3 = 3'd0; op1 = 32'd0; op2 = 32'd0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    chk("model_mul", ref_op(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    chk("model_mulhsu", ref_op(3'd2, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
    chk("model_div", ref_op(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("model_rem", ref_op(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

    // Back-to-back chain: each op starts in the previous op's done cycle
    run_op("mul",    3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33);
    run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    run_op("divu",   3'd5, 32'd100,       32'd7,         32'd14,        33);
    run_op("remu",   3'd7, 32'd100,       32'd7,         32'd2,         33);
    run_op("divu0",  3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run_op("rem0",   3'd6, 32'd5,         32'd0,         32'd5,         1);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    @(negedge clk);

    // Flush during cycle 10 of a divide
    func3 = 3'd4; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_after", {31'd0, busy}, 32'd0);
    seen = done;
    repeat (40) begin @(negedge clk); seen |= done; end
    chk("flush_no_done", {31'd0, seen}, 32'd0);

    // Reset in the middle of a multiply
    func3 = 3'd0; op1 = 32'd12345; op2 = 32'd678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); seen |= done; end
    chk("rst_no_done", {31'd0, seen}, 32'd0);

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 599) != 0);
      flush = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 3) == 0);
      func3 = 3'($urandom);
      op1   = pick_operand();
      op2   = pick_operand();
    end
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; start = 1'b0;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/m_ext_unit.md
M_EXT_UNIT -- requirements
Module: m_ext_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the operand and result width in bits (even, >= 8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-low.
REQ-004 SHALL have port start, input, 1, request to begin an operation with the current func3/op1/op2.
REQ-005 SHALL have port func3, input, 3, operation select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 SHALL have port op1, input, XLEN, rs1 operand (multiplicand/dividend).
REQ-007 SHALL have port op2, input, XLEN, rs2 operand (multiplier/divisor).
REQ-008 SHALL have port flush, input, 1, abort any in-flight operation (pipeline flush).
REQ-009 SHALL have port busy, output, 1, operation in progress; the core stalls EX while high.
REQ-010 SHALL have port done, output, 1, one-cycle pulse marking result valid.
REQ-011 SHALL have port result, output, XLEN, operation result.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV, DONE.
REQ-013 SHALL sample func3/op1/op2 only in the cycle start is accepted; later input changes SHALL NOT affect the operation.
REQ-014 SHALL accept start in IDLE or DONE.
REQ-015 SHALL ignore start while in MUL or DIV, with no effect on the operation in progress.
REQ-016 Transitions on accepted start: func3[2]=0 -> MUL; func3[2]=1 -> DIV, except the special cases of REQ-021/REQ-022, which go directly to DONE.
REQ-017 MUL and DIV SHALL iterate exactly XLEN cycles, one bit per cycle (shift-add multiply, restoring divide on operand magnitudes), then go to DONE.
REQ-018 Latency: for an accepted start at cycle 0:
- busy=1 in cycles 1..XLEN;
- done=1 and result valid in cycle XLEN+1, with busy=0;
- special cases: done in cycle 1.
REQ-019 DONE SHALL last one cycle, then go to IDLE (or MUL/DIV if start is accepted that cycle); result SHALL hold its value until the next done.
REQ-020 Signedness:
- MUL/MULH/DIV/REM treat both operands as signed;
- MULHSU treats op1 signed, op2 unsigned;
- MULHU/DIVU/REMU treat both as unsigned.
- The product is formed as 2*XLEN bits; MUL returns the low XLEN bits, MULH* the high XLEN bits.
- Quotient sign = XOR of operand signs; remainder sign = dividend sign.
REQ-021 Divide by zero (op2=0):
- DIV/DIVU quotient = all ones;
- REM/REMU = op1.
REQ-022 Signed overflow (DIV/REM with op1 = most-negative, op2 = all ones): quotient = op1, remainder = 0.
REQ-023 flush SHALL force the state to IDLE at the next edge, with busy=0 and no done for the aborted operation; result is unchanged.
REQ-024 flush SHALL take priority over a simultaneous start, which is then discarded.
REQ-025 done and busy SHALL never be high in the same cycle.

Reset
REQ-026 With rst=0 at a rising edge, the block SHALL enter IDLE with busy=0, done=0, result=0, and all iteration counters and datapath registers at 0, regardless of current state (including mid-operation).
REQ-027 An operation interrupted by reset SHALL produce no done.

Verification (XLEN=32)
REQ-028 Reset and multiply:
- reset, then MUL op1=7, op2=0xFFFFFFFD -> busy cycles 1..32, done at cycle 33, result=0xFFFFFFEB.
REQ-029 High-half multiplies:
- MULH 0x80000000*0x80000000 -> 0x40000000;
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE;
- MULHSU op1=0xFFFFFFFF, op2=2 -> 0xFFFFFFFF.
REQ-030 Signed divide:
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD;
- REM same operands -> 0xFFFFFFFF;
- DIVU 100/7 -> 14;
- REMU 100/7 -> 2.
REQ-031 Special cases:
- DIVU 5/0 -> 0xFFFFFFFF with done in cycle 1;
- REM 5/0 -> 5;
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000;
- REM same operands -> 0.
REQ-032 Abort and back-to-back:
- flush at cycle 10 of a DIV -> busy=0 at cycle 11, no done;
- rst=0 mid-MUL -> outputs all 0, no done;
- start asserted during busy is ignored;
- start asserted in the done cycle begins the next operation.
